sd_dat0_block_rx: RTL and testbench
===================================

// Module: sd_dat0_block_rx
// PURPOSE
//  Receives one SD single-bit (DAT0) read data block: start bit, BLK_BYTES payload bytes, CRC16, end bit.
//  Delivers payload as bytes and runs a CRC16 over the payload (x^16+x^12+x^5+1, init 0, MSB first).
//  Compares the result with the 16 received CRC bits, then reports pass/fail.
//  Sits between the SD pad sampling logic and the sector buffer; it is the checking end of the CRC16 generator.
// PARAMETERS
//  BLK_BYTES     512   payload bytes per block (1..4096)
//  TIMEOUT_BITS  65535 max BIT_EN strobes waited for the start bit before TIMEOUT
// PORTS
//  CLK        in   1   system clock; all logic rising-edge
//  RST_N      in   1   asynchronous active-low reset
//  BIT_EN     in   1   one-CLK strobe: DAT_IN holds a valid SD bit this cycle
//  DAT_IN     in   1   sampled DAT0 level
//  START      in   1   one-CLK pulse: arm receiver (ignored unless idle)
//  ABORT      in   1   one-CLK pulse: drop current block, return idle
//  BYTE_OUT   out  8   received payload byte, MSB = first bit on line
//  BYTE_VALID out  1   one-CLK pulse, BYTE_OUT valid
//  BUSY       out  1   high from accepted START until DONE/TIMEOUT/ABORT
//  DONE       out  1   one-CLK pulse, block finished (end bit sampled)
//  CRC_OK     out  1   level, valid from DONE until next START; received CRC == computed
//  CRC_ERR    out  1   level, same validity; received CRC != computed
//  END_ERR    out  1   level, same validity; end bit sampled as 0
//  TIMEOUT    out  1   one-CLK pulse; no start bit within TIMEOUT_BITS strobes
// BEHAVIOUR
//  Reset: all outputs 0, BYTE_OUT = 8'h00, state IDLE, CRC register 0, counters 0.
//  States: IDLE -> WAIT_SB -> DATA -> CRC -> ENDB -> IDLE. State advances only on BIT_EN, except START/ABORT.
//  IDLE: START -> WAIT_SB, BUSY=1, clear CRC register, bit/byte/timeout counters, and CRC_OK/CRC_ERR/END_ERR.
//  WAIT_SB: BIT_EN & DAT_IN=0 -> DATA; a start bit does not enter the CRC.
//   Each BIT_EN with DAT_IN=1 increments the timeout count.
//   On the TIMEOUT_BITS-th such strobe: TIMEOUT pulse, BUSY=0, -> IDLE.
//  DATA: each BIT_EN shifts DAT_IN into the byte shifter and steps the CRC LFSR (enable=1).
//   On the 8th bit of a byte, BYTE_OUT/BYTE_VALID are registered and appear on the CLK edge after that BIT_EN.
//   After byte BLK_BYTES-1 completes -> CRC.
//  CRC: 16 BIT_EN strobes shift received bits MSB-first into rx_crc; the LFSR is frozen. After the 16th bit -> ENDB.
//  ENDB: BIT_EN samples the end bit; END_ERR = ~DAT_IN.
//   CRC_OK = (rx_crc == crc), CRC_ERR = ~CRC_OK. Same edge: DONE pulse, BUSY=0, -> IDLE.
//  Latency: BYTE_VALID and DONE rise exactly 1 CLK after the qualifying BIT_EN.
//  BIT_EN gaps of any length: state and counters hold.
//  ABORT (any state): -> IDLE next edge, BUSY=0, no DONE/BYTE_VALID that cycle; ABORT wins over simultaneous BIT_EN or START.
//  START while BUSY: ignored. START and BIT_EN in the same IDLE cycle: arm only, the bit is not sampled.
//  Byte counter width = clog2(BLK_BYTES); bit counter is 3 bits and wraps 7->0 per byte; CRC bit counter is 4 bits.
//  Timeout counter width = clog2(TIMEOUT_BITS+1); saturates and never wraps.
//  RST_N low mid-block: immediate return to reset values; no partial DONE.
// STRUCTURE
//  Shared include sd_defines.vh: SD_CRC16_POLY = 16'h1021, state encodings, SD start/end bit levels.
//  Sub-module sd_crc16_lfsr: CLK, RST_N, sync CLR, EN, BITVAL -> CRC[15:0]; single-clock rewrite of the CRC16 LFSR, reused by the DAT transmitter.
//  Top: FSM, byte shifter, counters, rx_crc register, status flags.
// TESTING
//  1 BLK_BYTES=512, all bytes 8'hFF, CRC 16'h7FA1, end bit 1 -> 512 BYTE_VALIDs of 8'hFF, DONE, CRC_OK=1, END_ERR=0.
//  2 Same block, CRC bits sent as 16'h7FA0 -> DONE, CRC_ERR=1, CRC_OK=0; all 512 bytes still delivered.
//  3 Valid block, end bit 0 -> DONE, END_ERR=1, CRC_OK=1.
//  4 TIMEOUT_BITS=16, DAT_IN held 1 -> TIMEOUT on the CLK after the 16th BIT_EN; BUSY falls; no DONE.
//  5 ABORT after byte 100 -> BUSY=0 next CLK; no further BYTE_VALID. New START plus a good block -> CRC_OK=1, CRC restarted.
//  6 BIT_EN every 1st..7th CLK at random, RST_N pulsed mid-DATA -> outputs 0 at once. Bytes/CRC identical to a dense-strobe run.

Source files
------------

// File: rtl/sd_dat0_block_rx_pkg.sv
// Shared definitions for the SD DAT0 block receiver and the CRC16 generator:
// line levels, CRC polynomial, receiver state encoding and the CRC16 step.
package sd_dat0_block_rx_pkg;

  localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
  localparam logic        SD_START_BIT  = 1'b0;
  localparam logic        SD_END_BIT    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_SB = 3'd1,
    ST_DATA    = 3'd2,
    ST_CRC     = 3'd3,
    ST_ENDB    = 3'd4
  } rx_state_e;

  // One serial step of x^16+x^12+x^5+1, message bit entering MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bitval);
    logic fb;
    fb = crc[15] ^ bitval;
    return {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_lfsr.sv
// Serial CRC16 LFSR with synchronous clear and step enable; shared by the
// DAT receiver (checking) and the DAT transmitter (generating).
module sd_crc16_lfsr
  import sd_dat0_block_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bitval,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 16'h0000;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bitval);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_dat0_block_rx.sv
// SD DAT0 single-bit read block receiver: finds the start bit, delivers payload
// bytes, checks the trailing CRC16 against the running CRC and the end bit.
module sd_dat0_block_rx
  import sd_dat0_block_rx_pkg::*;
#(
  parameter int BLK_BYTES    = 512,
  parameter int TIMEOUT_BITS = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       dat_in,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       end_err,
  output logic       timeout
);

  localparam int BCW = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
  localparam int TCW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BLK_BYTES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_BITS - 1);
  localparam logic [TCW-1:0] TO_MAX    = TCW'(TIMEOUT_BITS);

  rx_state_e      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]     crc_cnt_q, crc_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    rx_crc_q, rx_crc_d;
  logic [7:0]     byte_out_q, byte_out_d;
  logic           byte_valid_q, byte_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           crc_ok_q, crc_ok_d;
  logic           crc_err_q, crc_err_d;
  logic           end_err_q, end_err_d;
  logic           timeout_q, timeout_d;
  logic           crc_clr;
  logic           crc_en;
  logic [15:0]    crc_calc;

  sd_crc16_lfsr u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bitval (dat_in),
    .crc    (crc_calc)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    crc_cnt_d    = crc_cnt_q;
    to_cnt_d     = to_cnt_q;
    shift_d      = shift_q;
    rx_crc_d     = rx_crc_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    crc_ok_d     = crc_ok_q;
    crc_err_d    = crc_err_q;
    end_err_d    = end_err_q;
    timeout_d    = 1'b0;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    // Abort outranks every strobe and START in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_WAIT_SB;
            busy_d     = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            crc_cnt_d  = '0;
            to_cnt_d   = '0;
            crc_clr    = 1'b1;
            crc_ok_d   = 1'b0;
            crc_err_d  = 1'b0;
            end_err_d  = 1'b0;
          end
        end
        ST_WAIT_SB: begin
          if (bit_en) begin
            if (dat_in == SD_START_BIT) begin
              state_d = ST_DATA;
            end else begin
              if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TCW'(1);
              if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
              end
            end
          end
        end
        ST_DATA: begin
          if (bit_en) begin
            crc_en    = 1'b1;
            shift_d   = {shift_q[6:0], dat_in};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_out_d   = {shift_q[6:0], dat_in};
              byte_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + BCW'(1);
              if (byte_cnt_q == BYTE_LAST) begin
                byte_cnt_d = '0;
                state_d    = ST_CRC;
              end
            end
          end
        end
        ST_CRC: begin
          if (bit_en) begin
            rx_crc_d  = {rx_crc_q[14:0], dat_in};
            crc_cnt_d = crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'd15) state_d = ST_ENDB;
          end
        end
        ST_ENDB: begin
          if (bit_en) begin
            end_err_d = (dat_in != SD_END_BIT);
            crc_ok_d  = (rx_crc_q == crc_calc);
            crc_err_d = (rx_crc_q != crc_calc);
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      crc_cnt_q    <= '0;
      to_cnt_q     <= '0;
      shift_q      <= '0;
      rx_crc_q     <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_cnt_q    <= crc_cnt_d;
      to_cnt_q     <= to_cnt_d;
      shift_q      <= shift_d;
      rx_crc_q     <= rx_crc_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      crc_ok_q     <= crc_ok_d;
      crc_err_q    <= crc_err_d;
      end_err_q    <= end_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign crc_ok     = crc_ok_q;
  assign crc_err    = crc_err_q;
  assign end_err    = end_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sd_dat0_block_rx.sv
// Randomized self-checking bench for sd_dat0_block_rx against a serial-line
// and CRC16 reference model built from the block format.
module tb_sd_dat0_block_rx;

  localparam int BLK = 512;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n, bit_en, dat_in, start, abort;
  logic [7:0] byte_out;
  logic       byte_valid, busy, done, crc_ok, crc_err, end_err, timeout;

  sd_dat0_block_rx #(.BLK_BYTES(BLK), .TIMEOUT_BITS(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .dat_in     (dat_in),
    .start      (start),
    .abort      (abort),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .end_err    (end_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rx_q[$];
  int         done_cnt = 0;
  int         to_seen  = 0;
  int         lat_err  = 0;
  logic [7:0] pay[BLK];

  always @(negedge clk) begin
    if (byte_valid) rx_q.push_back(byte_out);
    if (done) done_cnt++;
    if (timeout) to_seen++;
  end

  // Reference CRC16 over the payload as a polynomial remainder, bit by bit.
  function automatic logic [15:0] model_crc();
    logic [16:0] r;
    r = 17'h0;
    for (int i = 0; i < BLK; i++)
      for (int k = 7; k >= 0; k--) begin
        r = {r[15:0], 1'b0};
        if (r[16] ^ pay[i][k]) r = r ^ 17'h11021;
        r[16] = 1'b0;
      end
    return r[15:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    for (int i = 0; i < g; i++) cyc();
    bit_en = 1'b1;
    dat_in = b;
    cyc();
    bit_en = 1'b0;
    dat_in = 1'($urandom);
  endtask

  task automatic arm();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic fill_pay(input int mode);
    for (int i = 0; i < BLK; i++) pay[i] = (mode == 0) ? 8'hFF : 8'($urandom);
  endtask

  // Sends leading idle ones, start bit, payload, CRC^crc_xor, end bit.
  // Latency of BYTE_VALID/DONE relative to the qualifying strobe is tallied in lat_err.
  task automatic send_block(input int pre, input logic [15:0] crc_xor, input logic end_bit,
                            input int gap, input int start_at);
    logic [15:0] c;
    for (int i = 0; i < pre; i++) drive_bit(1'b1, gap);
    drive_bit(1'b0, gap);
    for (int i = 0; i < BLK; i++)
      for (int k = 7; k >= 0; k--) begin
        if (i == start_at && k == 3) start = 1'b1;
        drive_bit(pay[i][k], gap);
        start = 1'b0;
        if (k == 0) begin
          if (byte_valid !== 1'b1 || byte_out !== pay[i]) lat_err++;
        end else if (byte_valid !== 1'b0) lat_err++;
      end
    c = model_crc() ^ crc_xor;
    for (int k = 15; k >= 0; k--) drive_bit(c[k], gap);
    drive_bit(end_bit, gap);
    if (done !== 1'b1) lat_err++;
  endtask

  function automatic int pay_mismatch();
    int bad;
    bad = 0;
    if (rx_q.size() != BLK) return -1;
    for (int i = 0; i < BLK; i++) if (rx_q[i] !== pay[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; bit_en = 1'b0; dat_in = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) cyc();
    checks++;
    if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
    checks++;
    if ({byte_valid, busy, done, crc_ok, crc_err, end_err, timeout} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000",
                         {byte_valid, busy, done, crc_ok, crc_err, end_err, timeout});
    end
    rst_n = 1'b1;
    cyc();
    $display("tb: reset done");
  endtask

  task automatic test_good_block();
    int d0, bad;
    fill_pay(0);
    rx_q.delete(); lat_err = 0; d0 = done_cnt;
    arm();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_arm: got %b expected 1", busy); end
    send_block(3, 16'h0000, 1'b1, 0, -1);
    cyc();
    bad = pay_mismatch();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL good_bytes: got %0d bad (size %0d) expected 0 bad of %0d", bad, rx_q.size(), BLK); end
    checks++;
    if ({crc_ok, crc_err, end_err} !== 3'b100) begin errors++; $display("FAIL good_flags: got ok/err/end=%b expected 100", {crc_ok, crc_err, end_err}); end
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL good_done: got dones=%0d busy=%b expected 1 0", done_cnt - d0, busy); end
    checks++;
    if (lat_err !== 0) begin errors++; $display("FAIL good_latency: got %0d late pulses expected 0", lat_err); end
    $display("tb: block all-FF crc=%h bytes=%0d crc_ok=%b", model_crc(), rx_q.size(), crc_ok);
  endtask

  task automatic test_crc_err();
    int bad;
    fill_pay(0);
    rx_q.delete(); lat_err = 0;
    arm();
    send_block(0, 16'h0001, 1'b1, 0, -1);
    cyc();
    bad = pay_mismatch();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL crcerr_bytes: got %0d bad (size %0d) expected 0", bad, rx_q.size()); end
    checks++;
    if ({crc_ok, crc_err, end_err} !== 3'b010) begin errors++; $display("FAIL crcerr_flags: got ok/err/end=%b expected 010", {crc_ok, crc_err, end_err}); end
    $display("tb: block bad-crc crc_err=%b", crc_err);
  endtask

  task automatic test_end_err();
    int bad;
    fill_pay(1);
    rx_q.delete(); lat_err = 0;
    arm();
    send_block(int'($urandom_range(0, 10)), 16'h0000, 1'b0, 1, -1);
    cyc();
    bad = pay_mismatch();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL enderr_bytes: got %0d bad expected 0", bad); end
    checks++;
    if ({crc_ok, crc_err, end_err} !== 3'b101) begin errors++; $display("FAIL enderr_flags: got ok/err/end=%b expected 101", {crc_ok, crc_err, end_err}); end
    checks++;
    if (lat_err !== 0) begin errors++; $display("FAIL enderr_latency: got %0d expected 0", lat_err); end
    $display("tb: block random end-bit-0 end_err=%b crc_ok=%b", end_err, crc_ok);
  endtask

  task automatic test_timeout();
    int t0, d0;
    t0 = to_seen; d0 = done_cnt;
    arm();
    for (int i = 0; i < TO - 1; i++) drive_bit(1'b1, 2);
    checks++;
    if ({busy, timeout} !== 2'b10) begin errors++; $display("FAIL timeout_early: got busy/to=%b expected 10", {busy, timeout}); end
    drive_bit(1'b1, 2);
    checks++;
    if ({busy, timeout} !== 2'b01) begin errors++; $display("FAIL timeout_pulse: got busy/to=%b expected 01", {busy, timeout}); end
    cyc();
    checks++;
    if (timeout !== 1'b0 || to_seen - t0 !== 1 || done_cnt !== d0) begin
      errors++; $display("FAIL timeout_once: got to=%b pulses=%0d dones=%0d expected 0 1 0", timeout, to_seen - t0, done_cnt - d0);
    end
    $display("tb: timeout after %0d ones", TO);
  endtask

  task automatic test_abort();
    int n, bad, d0;
    fill_pay(1);
    rx_q.delete(); d0 = done_cnt;
    arm();
    drive_bit(1'b0, 0);
    for (int i = 0; i < 100; i++)
      for (int k = 7; k >= 0; k--) drive_bit(pay[i][k], 0);
    for (int k = 7; k >= 1; k--) drive_bit(pay[100][k], 0);
    abort = 1'b1;
    drive_bit(pay[100][0], 0);
    abort = 1'b0;
    checks++;
    if ({busy, byte_valid, done} !== 3'b000) begin errors++; $display("FAIL abort_now: got busy/bv/done=%b expected 000", {busy, byte_valid, done}); end
    n = rx_q.size();
    for (int i = 0; i < 40; i++) drive_bit(1'($urandom), 0);
    cyc();
    checks++;
    if (rx_q.size() !== 100 || n !== 100 || done_cnt !== d0) begin
      errors++; $display("FAIL abort_quiet: got bytes=%0d dones=%0d expected 100 0", rx_q.size(), done_cnt - d0);
    end
    fill_pay(1);
    rx_q.delete(); lat_err = 0;
    arm();
    send_block(2, 16'h0000, 1'b1, 0, -1);
    cyc();
    bad = pay_mismatch();
    checks++;
    if (bad !== 0 || crc_ok !== 1'b1 || lat_err !== 0) begin
      errors++; $display("FAIL abort_recover: got bad=%0d crc_ok=%b late=%0d expected 0 1 0", bad, crc_ok, lat_err);
    end
    $display("tb: abort after byte 100 then good block crc_ok=%b", crc_ok);
  endtask

  task automatic test_back_to_back();
    int bad;
    fill_pay(1);
    rx_q.delete(); lat_err = 0;
    start = 1'b1; bit_en = 1'b1; dat_in = 1'b0;
    cyc();
    start = 1'b0; bit_en = 1'b0;
    send_block(0, 16'h0000, 1'b1, 0, 10);
    bad = pay_mismatch();
    checks++;
    if (bad !== 0 || crc_ok !== 1'b1 || lat_err !== 0) begin
      errors++; $display("FAIL b2b_first: got bad=%0d crc_ok=%b late=%0d expected 0 1 0", bad, crc_ok, lat_err);
    end
    arm();
    checks++;
    if ({busy, crc_ok, crc_err, end_err} !== 4'b1000) begin
      errors++; $display("FAIL b2b_rearm: got busy/ok/err/end=%b expected 1000", {busy, crc_ok, crc_err, end_err});
    end
    fill_pay(1);
    rx_q.delete(); lat_err = 0;
    send_block(1, 16'h8000, 1'b1, 0, -1);
    bad = pay_mismatch();
    checks++;
    if (bad !== 0 || {crc_ok, crc_err} !== 2'b01 || lat_err !== 0) begin
      errors++; $display("FAIL b2b_second: got bad=%0d ok/err=%b late=%0d expected 0 01 0", bad, {crc_ok, crc_err}, lat_err);
    end
    $display("tb: back-to-back blocks second crc_err=%b", crc_err);
  endtask

  task automatic test_gaps_reset();
    int bad, d0;
    fill_pay(1);
    rx_q.delete();
    arm();
    drive_bit(1'b0, 6);
    for (int i = 0; i < 50; i++)
      for (int k = 7; k >= 0; k--) drive_bit(pay[i][k], 6);
    drive_bit(1'b1, 6);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy_pre: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_out, byte_valid, busy, done, crc_ok, crc_err, end_err, timeout} !== 15'b0) begin
      errors++; $display("FAIL gaps_async_reset: got %h expected 0",
                         {byte_out, byte_valid, busy, done, crc_ok, crc_err, end_err, timeout});
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    rx_q.delete(); lat_err = 0; d0 = done_cnt;
    arm();
    send_block(int'($urandom_range(0, 8)), 16'h0000, 1'b1, 6, -1);
    cyc();
    bad = pay_mismatch();
    checks++;
    if (bad !== 0 || {crc_ok, crc_err, end_err} !== 3'b100 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL gaps_block: got bad=%0d ok/err/end=%b dones=%0d expected 0 100 1",
                         bad, {crc_ok, crc_err, end_err}, done_cnt - d0);
    end
    checks++;
    if (lat_err !== 0) begin errors++; $display("FAIL gaps_latency: got %0d expected 0", lat_err); end
    $display("tb: sparse strobes with mid-block reset crc_ok=%b", crc_ok);
  endtask

  initial begin
    test_reset();
    test_good_block();
    test_crc_err();
    test_end_err();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_gaps_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
